// File: rtl/parametric_register_file.sv
// Two-read/one-write register file with hardwired zero register, optional
// write-to-read forwarding and a sequential clear engine that zeroes the array.
module parametric_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rsAddress,
    input  logic [ADDR_WIDTH-1:0] rtAddress,
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    input  logic                  registerRead,
    input  logic                  registerWrite,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  clearRequest,
    output logic [DATA_WIDTH-1:0] readValue0,
    output logic [DATA_WIDTH-1:0] readValue1,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] FIRST_INDEX = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_index_reg;
    logic [ADDR_WIDTH-1:0]   clear_index_next;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_data;
    logic [DATA_WIDTH-1:0]   registers [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= CLEAR;
            clear_index_reg <= FIRST_INDEX;
        end else begin
            state_reg       <= state_next;
            clear_index_reg <= clear_index_next;
        end
    end

    // The clear engine and the write port share the single array write port;
    // entry 0 is never cleared since it is masked to zero on every read.
    always_comb begin
        state_next       = state_reg;
        clear_index_next = clear_index_reg;
        mem_we           = 1'b0;
        mem_addr         = writeAddress;
        mem_data         = writeData;
        case (state_reg)
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clear_index_reg;
                mem_data = '0;
                if (clear_index_reg == LAST_INDEX) begin
                    state_next = IDLE;
                end else begin
                    clear_index_next = clear_index_reg + 1'b1;
                end
            end
            default: begin
                if (clearRequest) begin
                    state_next       = CLEAR;
                    clear_index_next = FIRST_INDEX;
                end else if (registerWrite && (writeAddress != '0)) begin
                    mem_we = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            registers[mem_addr] <= mem_data;
        end
    end

    assign busy = (state_reg == CLEAR);

    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [1:0][DATA_WIDTH-1:0] rd_data;

    assign rd_addr = {rtAddress, rsAddress};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            logic [DATA_WIDTH-1:0] value;
            always_comb begin
                value = '0;
                if (registerRead && !busy && (rd_addr[gi] != '0)) begin
                    if (BYPASS && registerWrite && (writeAddress == rd_addr[gi])) begin
                        value = writeData;
                    end else begin
                        value = registers[rd_addr[gi]];
                    end
                end
            end
            assign rd_data[gi] = value;
        end
    endgenerate

    assign readValue0 = rd_data[0];
    assign readValue1 = rd_data[1];

endmodule

// File: tb/tb_parametric_register_file.sv
// Directed bench: default bypassing instance, a non-bypassing twin on the same
// stimulus, and a 16-bit x 8-entry instance for the small-parameter cases.
module tb_parametric_register_file;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [4:0]  wr_addr = '0;
    logic        rd_en = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        clr_req = 1'b0;
    logic [31:0] a_rv0, a_rv1, b_rv0, b_rv1;
    logic        a_busy, b_busy;

    logic        c_rst = 1'b1;
    logic [2:0]  c_rs = '0;
    logic [2:0]  c_rt = '0;
    logic [2:0]  c_wa = '0;
    logic        c_rd = 1'b1;
    logic        c_we = 1'b0;
    logic [15:0] c_wd = '0;
    logic        c_clr = 1'b0;
    logic [15:0] c_rv0, c_rv1;
    logic        c_busy;

    int checks = 0;
    int errors = 0;
    int n;

    parametric_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rsAddress(rs_addr), .rtAddress(rt_addr),
        .writeAddress(wr_addr), .registerRead(rd_en), .registerWrite(wr_en),
        .writeData(wr_data), .clearRequest(clr_req),
        .readValue0(a_rv0), .readValue1(a_rv1), .busy(a_busy)
    );

    parametric_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rsAddress(rs_addr), .rtAddress(rt_addr),
        .writeAddress(wr_addr), .registerRead(rd_en), .registerWrite(wr_en),
        .writeData(wr_data), .clearRequest(clr_req),
        .readValue0(b_rv0), .readValue1(b_rv1), .busy(b_busy)
    );

    parametric_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(c_rst), .rsAddress(c_rs), .rtAddress(c_rt),
        .writeAddress(c_wa), .registerRead(c_rd), .registerWrite(c_we),
        .writeData(c_wd), .clearRequest(c_clr),
        .readValue0(c_rv0), .readValue1(c_rv1), .busy(c_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change one time unit after the rising edge; outputs are sampled
    // one further unit later, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset ----
        rs_addr = 5'd1; rt_addr = 5'd2;
        tick(); #1;
        chk("reset_busy_a", {31'd0, a_busy}, 32'd1);
        chk("reset_busy_b", {31'd0, b_busy}, 32'd1);
        chk("reset_rv0", a_rv0, 32'd0);
        chk("reset_rv1", a_rv1, 32'd0);
        tick();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
        chk("busy_at_release", {31'd0, a_busy}, 32'd1);
        n = 0;
        while (a_busy && n < 200) begin
            tick();
            n++;
        end
        wr_en = 1'b0;
        #1;
        $display("reset clear: busy cycles=%0d", n);
        chk("reset_clear_cycles", n, 32'd31);
        chk("reset_clear_cycles_b", {31'd0, b_busy}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i);
            #1;
            chk($sformatf("post_reset_r%0d_p0", i), a_rv0, 32'd0);
            chk($sformatf("post_reset_r%0d_p1", i), a_rv1, 32'd0);
        end
        rs_addr = 5'd5;
        #1;
        chk("busy_write_dropped_b", b_rv0, 32'd0);

        // ---- write / read ----
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        tick();
        wr_en = 1'b0; rs_addr = 5'd7; rt_addr = 5'd7;
        #1;
        $display("write r7=12345678: a=%h/%h b=%h/%h", a_rv0, a_rv1, b_rv0, b_rv1);
        chk("wr_r7_a_p0", a_rv0, 32'h12345678);
        chk("wr_r7_a_p1", a_rv1, 32'h12345678);
        chk("wr_r7_b_p0", b_rv0, 32'h12345678);
        chk("wr_r7_b_p1", b_rv1, 32'h12345678);
        rd_en = 1'b0;
        #1;
        chk("rd_dis_p0", a_rv0, 32'd0);
        chk("rd_dis_p1", a_rv1, 32'd0);
        rd_en = 1'b1;

        // ---- zero register ----
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        $display("write r0 same cycle: a=%h/%h", a_rv0, a_rv1);
        chk("r0_bypass_p0", a_rv0, 32'd0);
        chk("r0_bypass_p1", a_rv1, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r0_after_p0", a_rv0, 32'd0);
        chk("r0_after_p1", b_rv1, 32'd0);

        // ---- bypass ----
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        tick();
        wr_data = 32'h22; rs_addr = 5'd3; rt_addr = 5'd7;
        #1;
        $display("bypass r3: a=%h b=%h", a_rv0, b_rv0);
        chk("bypass_on", a_rv0, 32'h22);
        chk("bypass_off", b_rv0, 32'h11);
        chk("bypass_other_port", a_rv1, 32'h12345678);
        tick();
        wr_en = 1'b0;
        #1;
        chk("bypass_off_next", b_rv0, 32'h22);

        // ---- clear request ----
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
            tick();
        end
        wr_en = 1'b0; rs_addr = 5'd9; rt_addr = 5'd31;
        #1;
        chk("fill_r9", a_rv0, 32'd9);
        chk("fill_r31", b_rv1, 32'd31);
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
        tick();
        clr_req = 1'b0; wr_en = 1'b0;
        #1;
        chk("clr_busy_start", {31'd0, a_busy}, 32'd1);
        n = 0;
        while (a_busy && n < 200) begin
            clr_req = (n == 10);
            tick();
            n++;
        end
        clr_req = 1'b0;
        #1;
        $display("clear request: busy cycles=%0d", n);
        chk("clr_cycles", n, 32'd31);
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(i);
            #1;
            chk($sformatf("post_clr_r%0d_a", i), a_rv0, 32'd0);
            chk($sformatf("post_clr_r%0d_b", i), b_rv1, 32'd0);
        end

        // ---- small parameters ----
        tick();
        c_rst = 1'b0;
        #1;
        n = 0;
        while (c_busy && n < 200) begin
            tick();
            n++;
        end
        #1;
        $display("param reset: busy cycles=%0d", n);
        chk("c_reset_cycles", n, 32'd7);
        c_we = 1'b1; c_wa = 3'd7; c_wd = 16'hBEEF;
        tick();
        c_we = 1'b0; c_rs = 3'd7; c_rt = 3'd7;
        #1;
        $display("param r7: %h/%h", c_rv0, c_rv1);
        chk("c_r7_p0", {16'd0, c_rv0}, 32'h0000BEEF);
        chk("c_r7_p1", {16'd0, c_rv1}, 32'h0000BEEF);
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("c_busy_mid", {31'd0, c_busy}, 32'd1);
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0;
        #1;
        chk("c_busy_rst", {31'd0, c_busy}, 32'd1);
        n = 0;
        while (c_busy && n < 200) begin
            tick();
            n++;
        end
        #1;
        $display("param reset mid-clear: busy cycles=%0d", n);
        chk("c_restart_cycles", n, 32'd7);
        chk("c_r7_cleared", {16'd0, c_rv0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
